// File: rtl/processador_multiciclo_param.sv
// ============================================================================
//  Module      : processador_multiciclo_param
//  Description : Parametrised multicycle core with A/G/ALU datapath and a
//                shared bus. Executes mv, mvi, add, sub, and, or, slt, mvnz.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processador_multiciclo_param #(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 8,
    localparam int REG_W  = $clog2(NREGS),
    localparam int IR_W   = 3 + 2 * REG_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam logic [2:0] c_op_mv   = 3'b000;
    localparam logic [2:0] c_op_mvi  = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_sub  = 3'b011;
    localparam logic [2:0] c_op_and  = 3'b100;
    localparam logic [2:0] c_op_or   = 3'b101;
    localparam logic [2:0] c_op_slt  = 3'b110;
    localparam logic [2:0] c_op_mvnz = 3'b111;

    tstep_t              tstep_q, tstep_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   g_q, g_d;
    logic                z_q, z_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    logic [2:0]          w_op;
    logic [REG_W-1:0]    w_rx;
    logic [REG_W-1:0]    w_ry;
    logic                w_is_alu;

    logic                w_din_out;
    logic                w_g_out;
    logic                w_r_out;
    logic [REG_W-1:0]    w_r_sel;
    logic                w_r_in;
    logic                w_a_in;
    logic                w_g_in;
    logic                w_ir_in;
    logic                w_done;
    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_alu;

    assign w_op     = ir_q[IR_W-1 -: 3];
    assign w_rx     = ir_q[2*REG_W-1 -: REG_W];
    assign w_ry     = ir_q[REG_W-1:0];
    assign w_is_alu = (w_op != c_op_mv) && (w_op != c_op_mvi) && (w_op != c_op_mvnz);

    // Control decode; every strobe is held low while Reset is asserted so an
    // aborted instruction can never write back.
    always_comb begin
        w_din_out = 1'b0;
        w_g_out   = 1'b0;
        w_r_out   = 1'b0;
        w_r_sel   = '0;
        w_r_in    = 1'b0;
        w_a_in    = 1'b0;
        w_g_in    = 1'b0;
        w_ir_in   = 1'b0;
        w_done    = 1'b0;
        if (!Reset) begin
            case (tstep_q)
                T0: begin
                    if (Run) begin
                        w_din_out = 1'b1;
                        w_ir_in   = 1'b1;
                    end
                end
                T1: begin
                    case (w_op)
                        c_op_mv: begin
                            w_r_out = 1'b1;
                            w_r_sel = w_ry;
                            w_r_in  = 1'b1;
                            w_done  = 1'b1;
                        end
                        c_op_mvi: begin
                            w_din_out = 1'b1;
                            w_r_in    = 1'b1;
                            w_done    = 1'b1;
                        end
                        c_op_mvnz: begin
                            w_done = 1'b1;
                            if (!z_q) begin
                                w_r_out = 1'b1;
                                w_r_sel = w_ry;
                                w_r_in  = 1'b1;
                            end
                        end
                        default: begin
                            w_r_out = 1'b1;
                            w_r_sel = w_rx;
                            w_a_in  = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if (w_is_alu) begin
                        w_r_out = 1'b1;
                        w_r_sel = w_ry;
                        w_g_in  = 1'b1;
                    end
                end
                default: begin
                    if (w_is_alu) begin
                        w_g_out = 1'b1;
                        w_r_in  = 1'b1;
                        w_done  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_bus = '0;
        if (w_din_out) begin
            w_bus = DIN;
        end else if (w_g_out) begin
            w_bus = g_q;
        end else if (w_r_out) begin
            w_bus = regs_q[w_r_sel];
        end
    end

    always_comb begin
        case (w_op)
            c_op_add: w_alu = a_q + w_bus;
            c_op_sub: w_alu = a_q - w_bus;
            c_op_and: w_alu = a_q & w_bus;
            c_op_or:  w_alu = a_q | w_bus;
            c_op_slt: w_alu = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(w_bus))};
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        if (w_done) begin
            tstep_d = T0;
        end else if ((tstep_q == T0) && !Run) begin
            tstep_d = T0;
        end else begin
            tstep_d = tstep_t'(tstep_q + 2'd1);
        end
        ir_d   = w_ir_in ? DIN[IR_W-1:0] : ir_q;
        a_d    = w_a_in  ? w_bus : a_q;
        g_d    = w_g_in  ? w_alu : g_q;
        z_d    = w_g_in  ? (w_alu == '0) : z_q;
        regs_d = regs_q;
        if (w_r_in) begin
            regs_d[w_rx] = w_bus;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tstep_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            z_q     <= 1'b1;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            z_q     <= z_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign Done     = w_done;
    assign BusWires = w_bus;

endmodule

`default_nettype wire
